edge_gen: RTL and testbench

- Transmit-side counterpart to the level-to-edge detector.
- Accepts edge requests (rise or fall) over a valid/ready handshake and drives a registered, glitch-free output level.
- After each edge, the level is held stable for a programmable minimum time.
- Reports each generated edge, flags redundant requests, and counts edges. Sits upstream of any edge detector in the same clock domain.

---
 rtl/edge_gen.sv | 64 ++++++
 tb/tb_edge_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/edge_gen.sv
// Edge generator: turns accepted rise/fall requests into a registered output level,
// then holds that level for a programmable minimum number of cycles.
module edge_gen #(
  parameter int   HOLD_W      = 8,
  parameter int   CNT_W       = 16,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              req_valid,
  input  logic              req_rise,
  output logic              req_ready,
  output logic              out_level,
  output logic              edge_done,
  output logic              redundant,
  output logic [CNT_W-1:0]  edge_count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_eff;
  logic              accept;
  logic              real_edge;

  // A hold of zero is treated as one cycle, i.e. back-to-back edges are allowed.
  assign hold_eff  = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
  assign req_ready = (state == IDLE) & ~rst;
  assign accept    = req_valid & req_ready;
  assign real_edge = accept & (req_rise != out_level);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      out_level  <= RESET_LEVEL;
      edge_done  <= 1'b0;
      redundant  <= 1'b0;
      edge_count <= '0;
    end else begin
      edge_done <= real_edge;
      redundant <= accept & ~real_edge;
      if (real_edge) begin
        out_level  <= ~out_level;
        edge_count <= edge_count + CNT_W'(1);
        if (hold_eff > HOLD_W'(1)) begin
          state    <= HOLD;
          hold_cnt <= hold_eff - HOLD_W'(2);
        end
      end else if (state == HOLD) begin
        // The counter was loaded with H-2, so the exit edge gives H-1 cycles of not-ready.
        if (hold_cnt == '0) begin
          state <= IDLE;
        end else begin
          hold_cnt <= hold_cnt - HOLD_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_gen.sv
// Self-checking bench for edge_gen: directed vector table, hand-written corner
// sequences and randomized traffic against a cycle-time reference model.
module tb_edge_gen;

  localparam int HOLD_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [HOLD_W-1:0] hold_cycles;
  logic              req_valid;
  logic              req_rise;
  logic              req_ready, out_level, edge_done, redundant;
  logic [15:0]       edge_count;
  logic              req_ready4, out_level4, edge_done4, redundant4;
  logic [3:0]        edge_count4;

  edge_gen #(.HOLD_W(HOLD_W), .CNT_W(16), .RESET_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .hold_cycles(hold_cycles), .req_valid(req_valid),
    .req_rise(req_rise), .req_ready(req_ready), .out_level(out_level),
    .edge_done(edge_done), .redundant(redundant), .edge_count(edge_count)
  );

  edge_gen #(.HOLD_W(HOLD_W), .CNT_W(4), .RESET_LEVEL(1'b0)) dut4 (
    .clk(clk), .rst(rst), .hold_cycles(hold_cycles), .req_valid(req_valid),
    .req_rise(req_rise), .req_ready(req_ready4), .out_level(out_level4),
    .edge_done(edge_done4), .redundant(redundant4), .edge_count(edge_count4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: time-based, an edge at cycle n blocks requests until cycle n+H.
  int   cyc = 0;
  int   next_allowed = 0;
  logic m_level = 1'b0;
  int   m_count = 0;
  logic m_ready, m_done, m_red;
  logic seen_ready;

  typedef struct {
    logic        valid;
    logic        rise;
    logic [7:0]  hold;
    logic        ready;
    logic        level;
    logic        done;
    logic        red;
    int          count;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_level", 32'(out_level), 32'd0);
    chk("rst_count", 32'(edge_count), 32'd0);
    chk("rst_done", 32'(edge_done), 32'd0);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      chk("rst_hold_done", 32'(edge_done), 32'd0);
      chk("rst_hold_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    m_level = 1'b0;
    m_count = 0;
    next_allowed = cyc;
    m_done = 1'b0;
    m_red = 1'b0;
  endtask

  task automatic applyStimulus(input logic valid, input logic rise, input logic [7:0] hold);
    int h;
    @(negedge clk);
    req_valid = valid;
    req_rise = rise;
    hold_cycles = hold;
    #1;
    seen_ready = req_ready;
    m_ready = (cyc >= next_allowed);
    @(posedge clk);
    m_done = 1'b0;
    m_red = 1'b0;
    if (valid && m_ready) begin
      h = (hold == 0) ? 1 : int'(hold);
      if (rise != m_level) begin
        m_level = rise;
        m_count = m_count + 1;
        m_done = 1'b1;
        next_allowed = cyc + h;
      end else begin
        m_red = 1'b1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, "_ready"}, 32'(seen_ready), 32'(m_ready));
    chk({tag, "_level"}, 32'(out_level), 32'(m_level));
    chk({tag, "_done"}, 32'(edge_done), 32'(m_done));
    chk({tag, "_red"}, 32'(redundant), 32'(m_red));
    chk({tag, "_count"}, 32'(edge_count), 32'(m_count % 65536));
    chk({tag, "_count4"}, 32'(edge_count4), 32'(m_count % 16));
  endtask

  initial begin
    int steps;
    int ready_low;
    logic pend, pend_rise;
    logic [7:0] pend_hold;

    rst = 1'b1;
    req_valid = 1'b0;
    req_rise = 1'b0;
    hold_cycles = '0;

    vecs[0]  = '{1'b1, 1'b1, 8'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1};
    vecs[1]  = '{1'b0, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vecs[2]  = '{1'b1, 1'b1, 8'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1};
    vecs[3]  = '{1'b0, 1'b1, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vecs[4]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2};
    vecs[5]  = '{1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1, 2};
    vecs[6]  = '{1'b1, 1'b1, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0, 3};
    vecs[7]  = '{1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    vecs[8]  = '{1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    vecs[9]  = '{1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1, 1'b0, 4};
    vecs[10] = '{1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4};

    $display("[TB] directed vector table");
    doReset(2);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].rise, vecs[i].hold);
      chk($sformatf("vec%0d_ready", i), 32'(seen_ready), 32'(vecs[i].ready));
      chk($sformatf("vec%0d_level", i), 32'(out_level), 32'(vecs[i].level));
      chk($sformatf("vec%0d_done", i), 32'(edge_done), 32'(vecs[i].done));
      chk($sformatf("vec%0d_red", i), 32'(redundant), 32'(vecs[i].red));
      chk($sformatf("vec%0d_count", i), 32'(edge_count), 32'(vecs[i].count));
    end

    $display("[TB] hold_cycles=4 spacing");
    doReset(1);
    applyStimulus(1'b1, 1'b1, 8'd4);
    checkOutput("h4_rise");
    steps = 0;
    ready_low = 0;
    while (out_level == 1'b1 && steps < 20) begin
      applyStimulus(1'b1, 1'b0, 8'd4);
      checkOutput("h4_wait");
      if (!seen_ready) ready_low++;
      steps++;
    end
    chk("h4_high_cycles", 32'(steps), 32'd4);
    chk("h4_ready_low", 32'(ready_low), 32'd3);
    chk("h4_count", 32'(edge_count), 32'd2);

    $display("[TB] hold_cycles=0 alternating");
    doReset(1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, ~out_level, 8'd0);
      checkOutput("h0_alt");
      chk("h0_pulse", 32'(edge_done), 32'd1);
    end
    chk("h0_count", 32'(edge_count), 32'd8);

    $display("[TB] reset during hold");
    doReset(1);
    applyStimulus(1'b1, 1'b1, 8'd10);
    checkOutput("rh_rise");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 8'd10);
      checkOutput("rh_hold");
    end
    doReset(2);
    #1;
    chk("rh_ready_after", 32'(req_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'd1);
    checkOutput("rh_idle");

    $display("[TB] 4-bit counter wrap");
    doReset(1);
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(1'b1, ~out_level, 8'd1);
      checkOutput("wrap");
      if (i == 15) chk("wrap15", 32'(edge_count4), 32'd15);
      if (i == 16) chk("wrap16", 32'(edge_count4), 32'd0);
      if (i == 17) chk("wrap17", 32'(edge_count4), 32'd1);
    end

    $display("[TB] randomized traffic");
    doReset(1);
    pend = 1'b0;
    pend_rise = 1'b0;
    pend_hold = 8'd1;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        pend = ($urandom_range(0, 3) != 0);
        pend_rise = 1'($urandom_range(0, 1));
        pend_hold = 8'($urandom_range(0, 5));
      end
      applyStimulus(pend, pend_rise, pend_hold);
      checkOutput("rand");
      if (m_ready) pend = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
